// File: rtl/flux_beat_pkg.sv
// flux_beat_pkg: shared types, default widths and the beat threshold test
// used by the spectral-flux beat engine.
package flux_beat_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ANALYZE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int DEF_BINS       = 256;
    localparam int DEF_MAG_W      = 16;
    localparam int DEF_MAX_FRAMES = 4096;

    // Flux accumulator never overflows: BINS samples of at most 2^MAG_W-1 each.
    localparam int FLUX_W       = DEF_MAG_W + $clog2(DEF_BINS);
    localparam int FRAME_ADDR_W = $clog2(DEF_MAX_FRAMES);
    localparam int FRAME_CNT_W  = FRAME_ADDR_W + 1;

    // Beat candidate when flux clears the adaptive level avg*(1+2^-shift)
    // plus an absolute floor. Operands are zero-extended by the caller.
    function automatic logic flux_over_thr(input logic [63:0] flux,
                                           input logic [63:0] avg,
                                           input logic [63:0] floor_v,
                                           input int          shift);
        return flux > (avg + (avg >> shift) + floor_v);
    endfunction

endpackage

// File: rtl/beat_flag_ram.sv
// beat_flag_ram: one bit per analysed frame, one synchronous write port and
// one synchronous read port.
module beat_flag_ram #(
    parameter  int DEPTH = 4096,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic          i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic          o_rdata
);

    logic mem [DEPTH];

    // Write port: flag of the frame just decided.
    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
    end

    // Read port: registered output, updated only on an accepted playback tick.
    always_ff @(posedge i_clk) begin
        if (i_re) o_rdata <= mem[i_raddr];
    end

endmodule

// File: rtl/flux_beat_engine.sv
// flux_beat_engine: spectral-flux beat detector. Loading phase accumulates
// half-wave rectified flux per frame and stores a beat flag per frame;
// playback phase replays the flags as one-cycle pulses on frame ticks.
module flux_beat_engine
    import flux_beat_pkg::*;
#(
    parameter  int BINS       = DEF_BINS,
    parameter  int MAG_W      = DEF_MAG_W,
    parameter  int MAX_FRAMES = DEF_MAX_FRAMES,
    parameter  int AVG_SHIFT  = 3,
    parameter  int THR_SHIFT  = 1,
    parameter  int MIN_FLUX   = 1024,
    parameter  int REFRACT    = 8,
    localparam int BIN_W      = $clog2(BINS),
    localparam int ACC_W      = MAG_W + BIN_W,
    localparam int ADDR_W     = $clog2(MAX_FRAMES),
    localparam int CNT_W      = ADDR_W + 1,
    localparam int RF_W       = $clog2(REFRACT + 2)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_finish,
    input  logic [CNT_W-1:0] i_num_frames,
    input  logic             i_mag_valid,
    input  logic [MAG_W-1:0] i_mag,
    input  logic             i_mag_last,
    output logic             o_mag_ready,
    input  logic             i_frame_tick,
    input  logic             i_play_restart,
    output logic             o_beat,
    output logic             o_play_end,
    output logic [CNT_W-1:0] o_frame_count
);

    state_t                  state, state_nx;
    logic                    start_q, start_rise, restart;
    logic [CNT_W-1:0]        n_frames, n_eff, end_cnt, frame_idx, rd_ptr;
    logic [BIN_W-1:0]        bin_cnt;
    logic [MAG_W-1:0]        prev [BINS];
    logic [MAG_W-1:0]        diff_p0;
    logic [ACC_W-1:0]        flux_acc, flux_now, flux_p1;
    logic                    mag_ready, accept, frame_end, is_last;
    logic                    vld_p1, last_p1, beat_p1;
    logic signed [ACC_W:0]   avg, avg_nx;
    logic signed [ACC_W+1:0] avg_ext, avg_diff;
    logic [RF_W-1:0]         since;
    logic                    rd_en, rd_vld_p1, rd_flag, play_end;

    // Half-wave rectified difference: negative flux is discarded.
    function automatic logic [MAG_W-1:0] sat_sub(input logic [MAG_W-1:0] a,
                                                 input logic [MAG_W-1:0] b);
        return (a > b) ? a - b : '0;
    endfunction

    // Stage p0: sample acceptance, per-bin rectified flux and frame-end detect.
    always_comb begin
        start_rise = i_start & ~start_q;
        restart    = start_rise & (state != ANALYZE);
        n_eff      = (i_num_frames > CNT_W'(MAX_FRAMES)) ? CNT_W'(MAX_FRAMES) : i_num_frames;
        accept     = i_mag_valid & mag_ready;
        frame_end  = accept & (i_mag_last | (bin_cnt == BIN_W'(BINS - 1)));
        is_last    = (end_cnt == n_frames - CNT_W'(1));
        diff_p0    = sat_sub(i_mag, prev[bin_cnt]);
        flux_now   = flux_acc + ACC_W'(diff_p0);
    end

    // Stage p1: beat decision and running-average update for the completed frame.
    always_comb begin
        avg_ext  = {avg[ACC_W], avg};
        avg_diff = $signed({2'b00, flux_p1}) - avg_ext;
        avg_nx   = (ACC_W + 1)'(avg_ext + (avg_diff >>> AVG_SHIFT));
        beat_p1  = vld_p1 & (frame_idx != '0)
                 & flux_over_thr(64'(flux_p1), 64'(avg[ACC_W-1:0]), 64'(MIN_FLUX), THR_SHIFT)
                 & (since >= RF_W'(REFRACT));
        rd_en    = (state == DONE) & i_frame_tick & ~i_play_restart & (rd_ptr < frame_idx);
    end

    // Next-state logic: a zero-length run skips straight to DONE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start_rise) state_nx = (n_eff == '0) ? DONE : ANALYZE;
            ANALYZE:    if (last_p1) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // State register, start edge detect and registered ready (drops right after the final sample).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            mag_ready <= 1'b0;
            n_frames  <= '0;
        end else begin
            state     <= state_nx;
            start_q   <= i_start;
            mag_ready <= (state_nx == ANALYZE) & ~(frame_end & is_last);
            if (restart) n_frames <= n_eff;
        end
    end

    // Per-frame accumulation and previous-frame history; cleared on every new run.
    always_ff @(posedge i_clk) begin
        if (i_rst || restart) begin
            bin_cnt  <= '0;
            flux_acc <= '0;
            flux_p1  <= '0;
            end_cnt  <= '0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            for (int i = 0; i < BINS; i++) prev[i] <= '0;
        end else begin
            vld_p1  <= frame_end;
            last_p1 <= frame_end & is_last;
            if (accept) begin
                prev[bin_cnt] <= i_mag;
                flux_p1       <= flux_now;
                if (frame_end) begin
                    bin_cnt  <= '0;
                    flux_acc <= '0;
                    end_cnt  <= end_cnt + CNT_W'(1);
                end else begin
                    bin_cnt  <= bin_cnt + BIN_W'(1);
                    flux_acc <= flux_now;
                end
            end
        end
    end

    // Decision state: frame index, adaptive average and refractory counter.
    always_ff @(posedge i_clk) begin
        if (i_rst || restart) begin
            frame_idx <= '0;
            avg       <= '0;
            since     <= RF_W'(REFRACT);
        end else if (vld_p1) begin
            frame_idx <= frame_idx + CNT_W'(1);
            avg       <= avg_nx;
            if (beat_p1)                       since <= RF_W'(1);
            else if (since < RF_W'(REFRACT))   since <= since + RF_W'(1);
        end
    end

    // Playback pointer; restart wins over a simultaneous tick, no wrap at the end.
    always_ff @(posedge i_clk) begin
        if (i_rst || restart) begin
            rd_ptr    <= '0;
            rd_vld_p1 <= 1'b0;
            play_end  <= 1'b0;
        end else begin
            rd_vld_p1 <= rd_en;
            play_end  <= (state == DONE) & (rd_ptr == frame_idx);
            if ((state == DONE) && i_play_restart) rd_ptr <= '0;
            else if (rd_en)                        rd_ptr <= rd_ptr + CNT_W'(1);
        end
    end

    beat_flag_ram #(
        .DEPTH (MAX_FRAMES)
    ) u_flags (
        .i_clk   (i_clk),
        .i_we    (vld_p1),
        .i_waddr (frame_idx[ADDR_W-1:0]),
        .i_wdata (beat_p1),
        .i_re    (rd_en),
        .i_raddr (rd_ptr[ADDR_W-1:0]),
        .o_rdata (rd_flag)
    );

    assign o_finish      = (state == DONE);
    assign o_mag_ready   = mag_ready;
    assign o_beat        = rd_vld_p1 & rd_flag;
    assign o_play_end    = play_end;
    assign o_frame_count = frame_idx;

endmodule
